my_xor2_parity_rx: RTL and testbench

- Serial parity receiver; the receiving end of the registered-XOR parity path.
- Deserialises a framed bit stream (start strobe, data bits, one parity bit) qualified by a clock enable.
- Recomputes the running XOR of the frame and presents the data word, a parity-error flag and a saturating error count to downstream logic.
- Sits after the serial link as the checker for the parity-generating transmitter.

---
 rtl/my_xor2_parity_rx_if.sv | 25 ++
 rtl/my_xor2_parity_rx.sv | 98 +++++++++
 tb/tb_my_xor2_parity_rx.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/my_xor2_parity_rx_if.sv
// Receiver-side bus for the parity RX: clock enable, framed serial input,
// and the completed-word / error results handed to downstream logic.
interface my_xor2_parity_rx_if #(
  parameter int DATA_W = 8,
  parameter int ERR_W  = 8
);
  logic              CE;
  logic              IN_START;
  logic              IN_D;
  logic [DATA_W-1:0] O_DATA;
  logic              O_VALID;
  logic              O_PERR;
  logic [ERR_W-1:0]  O_ERR_CNT;
  logic              O_BUSY;

  modport master (
    output CE, IN_START, IN_D,
    input  O_DATA, O_VALID, O_PERR, O_ERR_CNT, O_BUSY
  );

  modport slave (
    input  CE, IN_START, IN_D,
    output O_DATA, O_VALID, O_PERR, O_ERR_CNT, O_BUSY
  );
endinterface

// File: rtl/my_xor2_parity_rx.sv
// Serial parity receiver: deserialises start/data/parity frames, rechecks the
// running XOR and reports the word, a parity-error flag and a saturating count.
module my_xor2_parity_rx #(
  parameter int DATA_W = 8,
  parameter bit ODD    = 1'b0,
  parameter int ERR_W  = 8
) (
  input logic                CLK,
  input logic                RESET,
  my_xor2_parity_rx_if.slave bus
);

  localparam int                CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   bit_cnt;
  logic               acc;
  logic [DATA_W-1:0]  shreg;
  logic [DATA_W-1:0]  data_q;
  logic               valid_q;
  logic               perr_q;
  logic [ERR_W-1:0]   err_cnt;
  logic               frame_done;
  logic               perr_next;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_next;
  end

  // A start strobe always wins, so it restarts the frame even on the parity edge.
  always_comb begin
    state_next = state;
    frame_done = 1'b0;
    perr_next  = (acc ^ bus.IN_D) != ODD;
    if (bus.CE) begin
      if (bus.IN_START) begin
        state_next = DATA;
      end else begin
        case (state)
          DATA: begin
            if (bit_cnt == LAST_BIT) state_next = PARITY;
          end
          PARITY: begin
            state_next = IDLE;
            frame_done = 1'b1;
          end
          default: state_next = state;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      bit_cnt <= '0;
      acc     <= 1'b0;
      shreg   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      err_cnt <= '0;
    end else begin
      valid_q <= 1'b0;
      if (bus.CE) begin
        if (bus.IN_START) begin
          bit_cnt <= '0;
          acc     <= 1'b0;
        end else if (state == DATA) begin
          shreg[bit_cnt] <= bus.IN_D;
          acc            <= acc ^ bus.IN_D;
          bit_cnt        <= bit_cnt + 1'b1;
        end
      end
      if (frame_done) begin
        data_q  <= shreg;
        perr_q  <= perr_next;
        valid_q <= 1'b1;
        if (perr_next && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
      end
    end
  end

  assign bus.O_DATA    = data_q;
  assign bus.O_VALID   = valid_q;
  assign bus.O_PERR    = perr_q;
  assign bus.O_ERR_CNT = err_cnt;
  assign bus.O_BUSY    = (state != IDLE);

endmodule

// File: tb/tb_my_xor2_parity_rx.sv
// Directed bench for the parity receiver: three instances (even, odd, 2-bit
// counter) share one stimulus stream; expected values are hand-computed.
`timescale 1ns/1ps
module tb_my_xor2_parity_rx;

  logic clk = 1'b0;
  logic reset;
  logic ce = 1'b0;
  logic in_start = 1'b0;
  logic in_d = 1'b0;
  int   vectors = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  my_xor2_parity_rx_if #(.DATA_W(8), .ERR_W(8)) bus0 ();
  my_xor2_parity_rx_if #(.DATA_W(8), .ERR_W(8)) bus_odd ();
  my_xor2_parity_rx_if #(.DATA_W(8), .ERR_W(2)) bus_e2 ();

  assign bus0.CE = ce;
  assign bus0.IN_START = in_start;
  assign bus0.IN_D = in_d;
  assign bus_odd.CE = ce;
  assign bus_odd.IN_START = in_start;
  assign bus_odd.IN_D = in_d;
  assign bus_e2.CE = ce;
  assign bus_e2.IN_START = in_start;
  assign bus_e2.IN_D = in_d;

  my_xor2_parity_rx #(.DATA_W(8), .ODD(1'b0), .ERR_W(8)) dut0 (
    .CLK(clk), .RESET(reset), .bus(bus0));
  my_xor2_parity_rx #(.DATA_W(8), .ODD(1'b1), .ERR_W(8)) dut_odd (
    .CLK(clk), .RESET(reset), .bus(bus_odd));
  my_xor2_parity_rx #(.DATA_W(8), .ODD(1'b0), .ERR_W(2)) dut_e2 (
    .CLK(clk), .RESET(reset), .bus(bus_e2));

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("[TB] %s miscompare", tag);
    end
  endtask

  // Inputs change on the falling edge; outputs are read 1ns after the rising edge.
  task automatic apply_stimulus(input logic ce_v, input logic start_v, input logic d_v);
    @(negedge clk);
    ce = ce_v;
    in_start = start_v;
    in_d = d_v;
    @(posedge clk);
    #1;
  endtask

  task automatic send_body(input logic [7:0] word, input logic par);
    for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 1'b0, word[i]);
    check_output("valid_before_parity", 32'(bus0.O_VALID), 32'd0);
    check_output("busy_before_parity", 32'(bus0.O_BUSY), 32'd1);
    apply_stimulus(1'b1, 1'b0, par);
  endtask

  task automatic send_frame(input logic [7:0] word, input logic par);
    apply_stimulus(1'b1, 1'b1, 1'b1);
    check_output("valid_after_start", 32'(bus0.O_VALID), 32'd0);
    send_body(word, par);
  endtask

  initial begin
    logic [7:0] w;
    reset = 1'b1;
    #0;
    reset = 1'b0;
    #0.05;
    check_output("rst_data", 32'(bus0.O_DATA), 32'h0);
    check_output("rst_valid", 32'(bus0.O_VALID), 32'd0);
    check_output("rst_perr", 32'(bus0.O_PERR), 32'd0);
    check_output("rst_cnt", 32'(bus0.O_ERR_CNT), 32'd0);
    check_output("rst_busy", 32'(bus0.O_BUSY), 32'd0);
    #0.05;
    reset = 1'b1;
    #0.1;
    check_output("busy_after_release", 32'(bus0.O_BUSY), 32'd0);

    $display("[TB] good even-parity frame 0xA5");
    send_frame(8'hA5, 1'b0);
    check_output("a5_valid", 32'(bus0.O_VALID), 32'd1);
    check_output("a5_data", 32'(bus0.O_DATA), 32'hA5);
    check_output("a5_perr", 32'(bus0.O_PERR), 32'd0);
    check_output("a5_cnt", 32'(bus0.O_ERR_CNT), 32'd0);
    check_output("a5_busy", 32'(bus0.O_BUSY), 32'd0);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    check_output("a5_valid_one_cycle", 32'(bus0.O_VALID), 32'd0);
    check_output("a5_data_hold", 32'(bus0.O_DATA), 32'hA5);

    $display("[TB] bad parity frame 0xA5, odd instance sees it as good");
    send_frame(8'hA5, 1'b1);
    check_output("a5bad_valid", 32'(bus0.O_VALID), 32'd1);
    check_output("a5bad_data", 32'(bus0.O_DATA), 32'hA5);
    check_output("a5bad_perr", 32'(bus0.O_PERR), 32'd1);
    check_output("a5bad_cnt", 32'(bus0.O_ERR_CNT), 32'd1);
    check_output("odd_perr", 32'(bus_odd.O_PERR), 32'd0);
    check_output("odd_valid", 32'(bus_odd.O_VALID), 32'd1);

    $display("[TB] frame 0x3C with a 3-cycle CE gap");
    w = 8'h3C;
    apply_stimulus(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        apply_stimulus(1'b0, 1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b1, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("gap_valid", 32'(bus0.O_VALID), 32'd0);
        check_output("gap_busy", 32'(bus0.O_BUSY), 32'd1);
      end
      apply_stimulus(1'b1, 1'b0, w[i]);
    end
    check_output("gap_no_early_valid", 32'(bus0.O_VALID), 32'd0);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    check_output("gap_valid_late", 32'(bus0.O_VALID), 32'd1);
    check_output("gap_data", 32'(bus0.O_DATA), 32'h3C);
    check_output("gap_perr", 32'(bus0.O_PERR), 32'd0);
    check_output("gap_cnt", 32'(bus0.O_ERR_CNT), 32'd1);

    $display("[TB] restart after 5 data bits, then frame 0x0F");
    apply_stimulus(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b0, 1'b1);
    send_frame(8'h0F, 1'b0);
    check_output("restart_valid", 32'(bus0.O_VALID), 32'd1);
    check_output("restart_data", 32'(bus0.O_DATA), 32'h0F);
    check_output("restart_perr", 32'(bus0.O_PERR), 32'd0);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    check_output("restart_single_valid", 32'(bus0.O_VALID), 32'd0);

    $display("[TB] start on the parity edge aborts, then frame 0x81");
    apply_stimulus(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 1'b0, 1'b1);
    apply_stimulus(1'b1, 1'b1, 1'b1);
    check_output("pstart_valid", 32'(bus0.O_VALID), 32'd0);
    check_output("pstart_busy", 32'(bus0.O_BUSY), 32'd1);
    check_output("pstart_data_hold", 32'(bus0.O_DATA), 32'h0F);
    check_output("pstart_cnt_hold", 32'(bus0.O_ERR_CNT), 32'd1);
    send_body(8'h81, 1'b0);
    check_output("p81_valid", 32'(bus0.O_VALID), 32'd1);
    check_output("p81_data", 32'(bus0.O_DATA), 32'h81);
    check_output("p81_perr", 32'(bus0.O_PERR), 32'd0);

    $display("[TB] asynchronous reset after 3 data bits");
    apply_stimulus(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check_output("midrst_busy", 32'(bus0.O_BUSY), 32'd0);
    check_output("midrst_valid", 32'(bus0.O_VALID), 32'd0);
    check_output("midrst_cnt", 32'(bus0.O_ERR_CNT), 32'd0);
    check_output("midrst_data", 32'(bus0.O_DATA), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    apply_stimulus(1'b1, 1'b0, 1'b1);
    check_output("postrst_valid", 32'(bus0.O_VALID), 32'd0);
    check_output("postrst_busy", 32'(bus0.O_BUSY), 32'd0);

    $display("[TB] 2-bit counter saturation");
    for (int n = 1; n <= 5; n++) begin
      send_frame(8'hA5, 1'b1);
      check_output("sat_perr", 32'(bus_e2.O_PERR), 32'd1);
      check_output("sat_cnt", 32'(bus_e2.O_ERR_CNT), (n < 3) ? 32'(n) : 32'd3);
    end
    check_output("wide_cnt", 32'(bus0.O_ERR_CNT), 32'd5);
    send_frame(8'h3C, 1'b0);
    check_output("sat_good_perr", 32'(bus_e2.O_PERR), 32'd0);
    check_output("sat_good_cnt", 32'(bus_e2.O_ERR_CNT), 32'd3);
    check_output("sat_good_data", 32'(bus_e2.O_DATA), 32'h3C);
    apply_stimulus(1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
